// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the instruction fetch unit.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam int          DEF_ROM_BYTES   = 100;
    localparam logic [5:0]  DEF_HALT_OPCODE = 6'b111111;

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch unit, its instruction store and the decode stage.
//
// Handshake: decode takes ins_out/pc_out on a rising edge where ins_valid=1
// and ins_ready=1. While ins_valid=1 and ins_ready=0 the fetch unit holds
// ins_out, pc_out and ins_valid unchanged. ins_valid does not depend
// combinationally on ins_ready.
interface fetch_if;
    import fetch_pkg::*;

    logic         InsMemRw;
    logic [31:0]  addr;
    logic [31:0]  dataIn;
    logic [31:0]  ins_out;
    logic [31:0]  pc_out;
    logic [31:0]  pc_plus4;
    logic         ins_valid;
    logic         ins_ready;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         halted;
    logic         fault;
    fetch_state_t state;      // debug view of the controller state

    // Fetch unit side.
    modport master (
        output InsMemRw, addr, ins_out, pc_out, pc_plus4, ins_valid,
               halted, fault, state,
        input  dataIn, ins_ready, redirect, redirect_pc
    );

    // Instruction store / decode side.
    modport slave (
        input  InsMemRw, addr, ins_out, pc_out, pc_plus4, ins_valid,
               halted, fault, state,
        output dataIn, ins_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: load (redirect) takes priority over increment.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    // PC update; increment wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one fetch per cycle from a combinational store,
// one-entry instruction register toward decode, redirect, halt and fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter int          ROM_BYTES   = DEF_ROM_BYTES,
    parameter logic [5:0]  HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic     CLK,
    input  logic     Reset,
    fetch_if.master  bus
);

    localparam logic [31:0] LAST_ADDR = 32'(ROM_BYTES - 4);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  ins_q;
    logic [31:0]  pc_out_q;
    logic         valid_q;
    logic         halted_q;
    logic         fault_q;

    logic         fetch_opp;
    logic         in_range;
    logic         do_redirect;
    logic         do_fetch;

    // A slot is free when the register is empty or being drained this edge.
    assign fetch_opp   = !valid_q || bus.ins_ready;
    assign in_range    = (pc <= LAST_ADDR);
    assign do_redirect = (state == RUN) && bus.redirect;
    assign do_fetch    = (state == RUN) && !bus.redirect && fetch_opp && in_range;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (CLK),
        .rst_n   (Reset),
        .load    (do_redirect),
        .inc     (do_fetch),
        .load_pc (align_word(bus.redirect_pc)),
        .pc      (pc)
    );

    // Controller and instruction register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            ins_q    <= 32'h0;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        // Held instruction is on the wrong path; drop it.
                        valid_q <= 1'b0;
                    end else if (fetch_opp) begin
                        if (in_range) begin
                            ins_q    <= bus.dataIn;
                            pc_out_q <= pc;
                            valid_q  <= 1'b1;
                            if (bus.dataIn[31:26] == HALT_OPCODE) begin
                                state    <= HALT;
                                halted_q <= 1'b1;
                            end
                        end else begin
                            valid_q <= 1'b0;
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (valid_q && bus.ins_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                FAULT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read enable follows the state register, so it never glitches.
    assign bus.InsMemRw  = (state == RUN);
    assign bus.addr      = pc;
    assign bus.ins_out   = ins_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.pc_plus4  = pc_out_q + 32'd4;
    assign bus.ins_valid = valid_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction store.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic CLK = 1'b0;
    logic Reset = 1'b0;

    fetch_if bus();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ROM_BYTES   (100),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    // Clock and reset block
    always #5 CLK = ~CLK;

    logic [31:0] mem [0:31];
    logic [31:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    // Instruction store: combinational read, zero outside the array.
    always_comb begin
        bus.dataIn = 32'h0;
        if (bus.addr < 32'd128) bus.dataIn = mem[bus.addr[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Reset for one cycle, release on a falling edge.
    task automatic do_reset();
        Reset = 1'b0;
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_valid"},  {31'b0, bus.ins_valid}, 32'd0);
        check({pfx, "_rw"},     {31'b0, bus.InsMemRw}, 32'd0);
        check({pfx, "_addr"},   bus.addr, 32'h0);
        check({pfx, "_ins"},    bus.ins_out, 32'h0);
        check({pfx, "_pc"},     bus.pc_out, 32'h0);
        check({pfx, "_halted"}, {31'b0, bus.halted}, 32'd0);
        check({pfx, "_fault"},  {31'b0, bus.fault}, 32'd0);
        check({pfx, "_state"},  32'(bus.state), 32'(IDLE));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;

        // ---- Reset state, sequential stream, stall, redirect ----
        @(negedge CLK);
        check_reset_vals("rst");
        Reset = 1'b1;
        tick();  // edge 1: IDLE -> RUN
        check("e1_valid", {31'b0, bus.ins_valid}, 32'd0);
        check("e1_state", 32'(bus.state), 32'(RUN));
        check("e1_rw", {31'b0, bus.InsMemRw}, 32'd1);
        check("e1_addr", bus.addr, 32'h0);
        tick();  // edge 2: first instruction valid
        check("e2_valid", {31'b0, bus.ins_valid}, 32'd1);
        check("e2_ins", bus.ins_out, 32'h1000_0000);
        check("e2_pc", bus.pc_out, 32'h0);
        check("e2_pc4", bus.pc_plus4, 32'h4);
        check("e2_addr", bus.addr, 32'h4);
        tick();
        check("e3_ins", bus.ins_out, 32'h1000_0111);
        check("e3_pc", bus.pc_out, 32'h4);
        bus.ins_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_ins", bus.ins_out, 32'h1000_0111);
            check("stall_pc", bus.pc_out, 32'h4);
            check("stall_addr", bus.addr, 32'h8);
            check("stall_valid", {31'b0, bus.ins_valid}, 32'd1);
        end
        bus.ins_ready = 1'b1;
        tick();
        check("post_stall_ins", bus.ins_out, 32'h1000_0222);
        check("post_stall_pc", bus.pc_out, 32'h8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0022;
        tick();
        check("redir_valid", {31'b0, bus.ins_valid}, 32'd0);
        check("redir_addr", bus.addr, 32'h20);
        bus.redirect = 1'b0;
        tick();
        check("redir_pc", bus.pc_out, 32'h20);
        check("redir_ins", bus.ins_out, 32'h1000_0888);
        check("redir_valid2", {31'b0, bus.ins_valid}, 32'd1);
        tick();
        check("redir_next_pc", bus.pc_out, 32'h24);

        // ---- Asynchronous reset in the middle of a stall ----
        bus.ins_ready = 1'b0;
        tick();
        check("pre_rst_pc", bus.pc_out, 32'h24);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge CLK);
        bus.ins_ready = 1'b1;
        Reset = 1'b1;
        tick();
        check("restart_state", 32'(bus.state), 32'(RUN));
        tick();
        check("restart_pc", bus.pc_out, 32'h0);
        check("restart_ins", bus.ins_out, 32'h1000_0000);

        // ---- Halt, with redirect beating a halt word ----
        mem[3] = 32'hFC00_0000;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        check("h_pc8", bus.pc_out, 32'h8);
        check("h_addr12", bus.addr, 32'hC);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        check("h_redir_valid", {31'b0, bus.ins_valid}, 32'd0);
        check("h_redir_halted", {31'b0, bus.halted}, 32'd0);
        check("h_redir_state", 32'(bus.state), 32'(RUN));
        check("h_redir_addr", bus.addr, 32'h0);
        bus.redirect = 1'b0;
        tick();
        tick();
        tick();
        check("h_refetch_pc", bus.pc_out, 32'h8);
        tick();
        check("halt_ins", bus.ins_out, 32'hFC00_0000);
        check("halt_pc", bus.pc_out, 32'hC);
        check("halt_flag", {31'b0, bus.halted}, 32'd1);
        check("halt_rw", {31'b0, bus.InsMemRw}, 32'd0);
        check("halt_valid", {31'b0, bus.ins_valid}, 32'd1);
        check("halt_state", 32'(bus.state), 32'(HALT));
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        check("halt_hold_valid", {31'b0, bus.ins_valid}, 32'd1);
        check("halt_hold_pc", bus.pc_out, 32'hC);
        check("halt_noredir_addr", bus.addr, 32'h10);
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b0;
        tick();
        check("halt_drained", {31'b0, bus.ins_valid}, 32'd0);
        check("halt_still", {31'b0, bus.halted}, 32'd1);
        tick();
        check("halt_no16", bus.pc_out, 32'hC);
        check("halt_rw2", {31'b0, bus.InsMemRw}, 32'd0);

        // ---- Sequential run to the end of the store, then fault ----
        mem[3] = 32'h1000_0333;
        do_reset();
        tick();
        for (int i = 0; i < 25; i++) exp_q.push_back(32'(i) * 32'd4);
        for (int i = 0; i < 25; i++) begin
            logic [31:0] e;
            tick();
            e = exp_q.pop_front();
            check("seq_pc", bus.pc_out, e);
            check("seq_ins", bus.ins_out, mem[e[6:2]]);
        end
        check("last_pc", bus.pc_out, 32'd96);
        check("last_valid", {31'b0, bus.ins_valid}, 32'd1);
        tick();
        check("fault_flag", {31'b0, bus.fault}, 32'd1);
        check("fault_valid", {31'b0, bus.ins_valid}, 32'd0);
        check("fault_rw", {31'b0, bus.InsMemRw}, 32'd0);
        check("fault_state", 32'(bus.state), 32'(FAULT));
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        check("fault_sticky", {31'b0, bus.fault}, 32'd1);
        check("fault_noredir_state", 32'(bus.state), 32'(FAULT));
        check("fault_noredir_addr", bus.addr, 32'd100);
        check("fault_noredir_valid", {31'b0, bus.ins_valid}, 32'd0);
        bus.redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
